trace_input_arbiter: RTL and testbench

TRACE_INPUT_ARBITER -- requirements
Module: trace_input_arbiter

---
 rtl/trace_input_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_trace_input_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_input_arbiter.sv
// trace_input_arbiter
//   Arbitrates NUM_SRC trace sources onto the single debugger vector input.
//   Idle arbitration is round-robin starting at ptr. A source that starts a
//   frame with a non-eof beat keeps the grant until its eof beat, so frames
//   from different sources never interleave. The accepted beat is registered
//   and presented one cycle later with a single-cycle enqueue pulse.
//
//   Optional feature: define ARB_WATCHDOG_EN to compile in the owner
//   watchdog. While a source holds the lock without offering data and the
//   debugger is not stalling, a counter advances. After WDOG_CYCLES such
//   cycles the lock is dropped and the sticky timeout_err flag is raised.
//   In the default build there is no counter, timeout_err is tied low and
//   the lock is held indefinitely.
//
// Ports
//   clk          single clock, all logic on posedge
//   reset        synchronous active-high reset
//   req_valid    per-source beat valid           [NUM_SRC]
//   req_vector   per-source beat, source s at slice s, lane k inside it
//   req_eof      per-source eof, bit0 end of frame, bit1 end of trace
//   req_ready    per-source accept (combinational, at most one high)
//   stall        debugger input-buffer backpressure
//   vector_out   registered forwarded beat
//   enqueue      registered one-cycle pulse per forwarded beat
//   eof_out      registered eof of forwarded beat
//   src_id       registered source index of forwarded beat
//   timeout_err  sticky watchdog flag
module trace_input_arbiter #(
    parameter int N           = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SRC     = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             req_valid,
    input  logic [NUM_SRC*N*DATA_WIDTH-1:0] req_vector,
    input  logic [NUM_SRC*2-1:0]           req_eof,
    output logic [NUM_SRC-1:0]             req_ready,
    input  logic                           stall,
    output logic [N*DATA_WIDTH-1:0]        vector_out,
    output logic                           enqueue,
    output logic [1:0]                     eof_out,
    output logic [$clog2(NUM_SRC)-1:0]     src_id,
    output logic                           timeout_err
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int VW = N * DATA_WIDTH;

    if (NUM_SRC < 2 || WDOG_CYCLES < 1) begin : g_bad_params
        $error("trace_input_arbiter: NUM_SRC must be >= 2 and WDOG_CYCLES >= 1");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   owner_q, owner_d;
    logic [VW-1:0]   vector_q, vector_d;
    logic            enqueue_q, enqueue_d;
    logic [1:0]      eof_q, eof_d;
    logic [SW-1:0]   src_id_q, src_id_d;

    logic            any_valid;
    logic            found_hi;
    logic [SW-1:0]   win_hi, win_lo, winner;
    logic [SW-1:0]   sel;
    logic            sel_valid;
    logic [1:0]      sel_eof;
    logic [VW-1:0]   sel_vec;
    logic            ready_en;
    logic            accept;

    function automatic logic [SW-1:0] next_src(input logic [SW-1:0] idx);
        return (idx == SW'(NUM_SRC - 1)) ? '0 : idx + SW'(1);
    endfunction

    // Round-robin winner from ptr upward: the first valid source at or
    // above ptr wins; otherwise wrap and take the first valid one overall.
    always_comb begin
        found_hi = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int unsigned s = NUM_SRC; s > 0; s--) begin
            if (req_valid[s-1]) begin
                win_lo = SW'(s - 1);
            end
        end
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (!found_hi && req_valid[s] && (SW'(s) >= ptr_q)) begin
                found_hi = 1'b1;
                win_hi   = SW'(s);
            end
        end
        winner    = found_hi ? win_hi : win_lo;
        any_valid = |req_valid;
    end

    // The granted source is the owner while locked, else the idle winner.
    always_comb begin
        sel       = (state_q == LOCKED) ? owner_q : winner;
        sel_valid = 1'b0;
        sel_eof   = '0;
        sel_vec   = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (SW'(s) == sel) begin
                sel_valid = req_valid[s];
                sel_eof   = req_eof[2*s +: 2];
                sel_vec   = req_vector[s*VW +: VW];
            end
        end
    end

    // The owner sees ready even without valid so that it can resume at once.
    always_comb begin
        ready_en  = !reset && !stall && ((state_q == LOCKED) || any_valid);
        req_ready = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            req_ready[s] = ready_en && (SW'(s) == sel);
        end
        accept = ready_en && sel_valid;
    end

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        enqueue_d = accept;
        vector_d  = vector_q;
        eof_d     = eof_q;
        src_id_d  = src_id_q;

        if (accept) begin
            vector_d = sel_vec;
            eof_d    = sel_eof;
            src_id_d = sel;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_eof != 2'b00) begin
                        ptr_d = next_src(sel);
                    end else begin
                        state_d = LOCKED;
                        owner_d = sel;
                    end
                end
            end
            LOCKED: begin
                if (accept && (sel_eof != 2'b00)) begin
                    state_d = IDLE;
                    ptr_d   = next_src(owner_q);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef ARB_WATCHDOG_EN
        timeout_d  = timeout_q;
        wdog_cnt_d = '0;
        // Only an idle owner with no backpressure counts; accept or stall
        // fall through to the cleared default.
        if ((state_q == LOCKED) && !sel_valid && !stall) begin
            if (wdog_cnt_q == CW'(WDOG_CYCLES - 1)) begin
                state_d   = IDLE;
                ptr_d     = next_src(owner_q);
                timeout_d = 1'b1;
            end else begin
                wdog_cnt_d = wdog_cnt_q + CW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            vector_q  <= '0;
            enqueue_q <= 1'b0;
            eof_q     <= '0;
            src_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            vector_q  <= vector_d;
            enqueue_q <= enqueue_d;
            eof_q     <= eof_d;
            src_id_q  <= src_id_d;
        end
    end

`ifdef ARB_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign vector_out = vector_q;
    assign enqueue    = enqueue_q;
    assign eof_out    = eof_q;
    assign src_id     = src_id_q;

endmodule

// File: tb/tb_trace_input_arbiter.sv
// Directed bench for trace_input_arbiter (N=16, DATA_WIDTH=32, NUM_SRC=4,
// WDOG_CYCLES=8). Inputs change 1 time unit after posedge; combinational
// req_ready is checked 1 unit later, registered outputs after the next edge.
`define CHK(tag, obs, exp) \
  begin \
    n_assert++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
  end

`define CHKV(tag, exp) \
  begin \
    n_assert++; \
    assert (vector_out === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s: observed low64 %0h expected low64 %0h", tag, vector_out[63:0], exp[63:0]); \
    end \
  end

module tb_trace_input_arbiter;

  localparam int N   = 16;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int VW  = N * DW;

  logic               clk = 1'b0;
  logic               reset;
  logic [NS-1:0]      req_valid;
  logic [NS*VW-1:0]   req_vector;
  logic [NS*2-1:0]    req_eof;
  logic [NS-1:0]      req_ready;
  logic               stall;
  logic [VW-1:0]      vector_out;
  logic               enqueue;
  logic [1:0]         eof_out;
  logic [1:0]         src_id;
  logic               timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic [VW-1:0] exp_vec;

  always #5 clk = ~clk;

  trace_input_arbiter #(
    .N           (N),
    .DATA_WIDTH  (DW),
    .NUM_SRC     (NS),
    .WDOG_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_vector  (req_vector),
    .req_eof     (req_eof),
    .req_ready   (req_ready),
    .stall       (stall),
    .vector_out  (vector_out),
    .enqueue     (enqueue),
    .eof_out     (eof_out),
    .src_id      (src_id),
    .timeout_err (timeout_err)
  );

  // Each lane tags source, beat number and lane index.
  function automatic logic [VW-1:0] mk_vec(input int s, input int b);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) begin
      v[k*DW +: DW] = {8'(s), 8'(b), 8'h5A, 8'(k)};
    end
    return v;
  endfunction

  task automatic set_src(input int s, input logic v, input int b, input logic [1:0] e);
    req_valid[s]           = v;
    req_vector[s*VW +: VW] = mk_vec(s, b);
    req_eof[2*s +: 2]      = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_vector = '0;
    req_eof    = '0;
    stall      = 1'b0;

    // Reset: beat offered during reset is not accepted.
    set_src(0, 1'b1, 0, 2'b01);
    #1;
    `CHK("rst_ready", req_ready, 4'b0000)
    tick();
    tick();
    `CHK("rst_enq", enqueue, 1'b0)
    `CHK("rst_eof", eof_out, 2'b00)
    `CHK("rst_src", src_id, 2'd0)
    `CHK("rst_tmo", timeout_err, 1'b0)
    exp_vec = '0;
    `CHKV("rst_vec", exp_vec)
    reset = 1'b0;
    set_src(0, 1'b0, 0, 2'b00);

    // Single source: src1 sends a 3-beat frame.
    for (int b = 0; b < 3; b++) begin
      set_src(1, 1'b1, b, (b == 2) ? 2'b01 : 2'b00);
      #1;
      n_assert++;
      if (req_ready !== 4'b0010) begin
        n_fail++;
        $error("FAIL single_ready: observed %0h", req_ready);
      end
      tick();
      n_assert++;
      if (enqueue !== 1'b1) begin
        n_fail++;
        $error("FAIL single_enq: observed %0h", enqueue);
      end
      n_assert++;
      if (src_id !== 2'd1) begin
        n_fail++;
        $error("FAIL single_src: observed %0h", src_id);
      end
      n_assert++;
      if (eof_out !== ((b == 2) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $error("FAIL single_eof: observed %0h", eof_out);
      end
      exp_vec = mk_vec(1, b);
      n_assert++;
      if (vector_out !== exp_vec) begin
        n_fail++;
        $error("FAIL single_vec: observed low64 %0h", vector_out[63:0]);
      end
    end
    set_src(1, 1'b0, 0, 2'b00);
    #1;
    `CHK("idle_ready", req_ready, 4'b0000)
    tick();
    `CHK("idle_enq", enqueue, 1'b0)
    `CHK("idle_eof_hold", eof_out, 2'b01)
    exp_vec = mk_vec(1, 2);
    `CHKV("idle_vec_hold", exp_vec)

    // Fairness: all four valid with single-beat frames.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int s = 0; s < NS; s++) set_src(s, 1'b1, 32, 2'b01);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_assert++;
      if (req_ready !== 4'(1 << (i % 4))) begin
        n_fail++;
        $error("FAIL rr_ready: observed %0h", req_ready);
      end
      tick();
      n_assert++;
      if (enqueue !== 1'b1) begin
        n_fail++;
        $error("FAIL rr_enq: observed %0h", enqueue);
      end
      n_assert++;
      if (src_id !== 2'(i % 4)) begin
        n_fail++;
        $error("FAIL rr_src: observed %0h expected %0h", src_id, i % 4);
      end
      exp_vec = mk_vec(i % 4, 32);
      n_assert++;
      if (vector_out !== exp_vec) begin
        n_fail++;
        $error("FAIL rr_vec: observed low64 %0h", vector_out[63:0]);
      end
    end
    for (int s = 0; s < NS; s++) set_src(s, 1'b0, 0, 2'b00);

    // Frame lock: src0 4-beat frame while src2 waits.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_src(2, 1'b1, 48, 2'b01);
    for (int b = 0; b < 4; b++) begin
      set_src(0, 1'b1, b, (b == 3) ? 2'b01 : 2'b00);
      #1;
      n_assert++;
      if (req_ready !== 4'b0001) begin
        n_fail++;
        $error("FAIL lock_ready: observed %0h", req_ready);
      end
      tick();
      n_assert++;
      if (src_id !== 2'd0) begin
        n_fail++;
        $error("FAIL lock_src: observed %0h", src_id);
      end
      n_assert++;
      if (enqueue !== 1'b1) begin
        n_fail++;
        $error("FAIL lock_enq: observed %0h", enqueue);
      end
      exp_vec = mk_vec(0, b);
      n_assert++;
      if (vector_out !== exp_vec) begin
        n_fail++;
        $error("FAIL lock_vec: observed low64 %0h", vector_out[63:0]);
      end
    end
    set_src(0, 1'b0, 0, 2'b00);
    #1;
    `CHK("lock_next_ready", req_ready, 4'b0100)
    tick();
    `CHK("lock_next_enq", enqueue, 1'b1)
    `CHK("lock_next_src", src_id, 2'd2)
    exp_vec = mk_vec(2, 48);
    `CHKV("lock_next_vec", exp_vec)
    set_src(2, 1'b0, 0, 2'b00);

    // Stall mid-frame of src3 with src0 waiting.
    for (int b = 0; b < 2; b++) begin
      set_src(3, 1'b1, b, 2'b00);
      #1;
      n_assert++;
      if (req_ready !== 4'b1000) begin
        n_fail++;
        $error("FAIL stall_pre_ready: observed %0h", req_ready);
      end
      tick();
      n_assert++;
      if (src_id !== 2'd3) begin
        n_fail++;
        $error("FAIL stall_pre_src: observed %0h", src_id);
      end
      exp_vec = mk_vec(3, b);
      n_assert++;
      if (vector_out !== exp_vec) begin
        n_fail++;
        $error("FAIL stall_pre_vec: observed low64 %0h", vector_out[63:0]);
      end
    end
    stall = 1'b1;
    set_src(3, 1'b1, 2, 2'b00);
    set_src(0, 1'b1, 64, 2'b01);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_assert++;
      if (req_ready !== 4'b0000) begin
        n_fail++;
        $error("FAIL stall_ready: observed %0h", req_ready);
      end
      tick();
      n_assert++;
      if (enqueue !== 1'b0) begin
        n_fail++;
        $error("FAIL stall_enq: observed %0h", enqueue);
      end
      exp_vec = mk_vec(3, 1);
      n_assert++;
      if (vector_out !== exp_vec) begin
        n_fail++;
        $error("FAIL stall_vec_hold: observed low64 %0h", vector_out[63:0]);
      end
    end
    stall = 1'b0;
    for (int b = 2; b < 5; b++) begin
      set_src(3, 1'b1, b, (b == 4) ? 2'b01 : 2'b00);
      #1;
      n_assert++;
      if (req_ready !== 4'b1000) begin
        n_fail++;
        $error("FAIL stall_post_ready: observed %0h", req_ready);
      end
      tick();
      n_assert++;
      if (enqueue !== 1'b1) begin
        n_fail++;
        $error("FAIL stall_post_enq: observed %0h", enqueue);
      end
      n_assert++;
      if (src_id !== 2'd3) begin
        n_fail++;
        $error("FAIL stall_post_src: observed %0h", src_id);
      end
      n_assert++;
      if (eof_out !== ((b == 4) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $error("FAIL stall_post_eof: observed %0h", eof_out);
      end
      exp_vec = mk_vec(3, b);
      n_assert++;
      if (vector_out !== exp_vec) begin
        n_fail++;
        $error("FAIL stall_post_vec: observed low64 %0h", vector_out[63:0]);
      end
    end
    set_src(3, 1'b0, 0, 2'b00);
    #1;
    `CHK("after_stall_ready", req_ready, 4'b0001)
    tick();
    `CHK("after_stall_src", src_id, 2'd0)

    // Reset mid-frame of src1 (ptr is 1, src0 still valid).
    set_src(1, 1'b1, 0, 2'b00);
    #1;
    `CHK("rmf_ready", req_ready, 4'b0010)
    tick();
    `CHK("rmf_src", src_id, 2'd1)
    set_src(1, 1'b1, 1, 2'b00);
    reset = 1'b1;
    #1;
    `CHK("rmf_rst_ready", req_ready, 4'b0000)
    tick();
    reset = 1'b0;
    `CHK("rmf_enq", enqueue, 1'b0)
    `CHK("rmf_src_clr", src_id, 2'd0)
    #1;
    `CHK("rmf_win_ready", req_ready, 4'b0001)
    tick();
    `CHK("rmf_win_enq", enqueue, 1'b1)
    `CHK("rmf_win_src", src_id, 2'd0)
    exp_vec = mk_vec(0, 64);
    `CHKV("rmf_win_vec", exp_vec)
    set_src(0, 1'b0, 0, 2'b00);
    set_src(1, 1'b0, 0, 2'b00);

    // Owner goes silent for 8 cycles after locking (ptr is 1).
    set_src(2, 1'b1, 80, 2'b00);
    set_src(3, 1'b1, 96, 2'b01);
    #1;
    `CHK("wd_lock_ready", req_ready, 4'b0100)
    tick();
    `CHK("wd_lock_src", src_id, 2'd2)
    set_src(2, 1'b0, 80, 2'b00);
    for (int i = 0; i < 8; i++) begin
      #1;
      n_assert++;
      if (req_ready !== 4'b0100) begin
        n_fail++;
        $error("FAIL wd_hold_ready: observed %0h", req_ready);
      end
      tick();
      n_assert++;
      if (enqueue !== 1'b0) begin
        n_fail++;
        $error("FAIL wd_hold_enq: observed %0h", enqueue);
      end
    end
`ifdef ARB_WATCHDOG_EN
    `CHK("wd_tmo", timeout_err, 1'b1)
    #1;
    `CHK("wd_next_ready", req_ready, 4'b1000)
    tick();
    `CHK("wd_next_enq", enqueue, 1'b1)
    `CHK("wd_next_src", src_id, 2'd3)
    `CHK("wd_tmo_sticky", timeout_err, 1'b1)
`else
    `CHK("nowd_tmo", timeout_err, 1'b0)
    #1;
    `CHK("nowd_ready", req_ready, 4'b0100)
    tick();
    `CHK("nowd_enq", enqueue, 1'b0)
    set_src(2, 1'b1, 81, 2'b01);
    #1;
    `CHK("nowd_resume_ready", req_ready, 4'b0100)
    tick();
    `CHK("nowd_resume_src", src_id, 2'd2)
    exp_vec = mk_vec(2, 81);
    `CHKV("nowd_resume_vec", exp_vec)
    set_src(2, 1'b0, 0, 2'b00);
    #1;
    `CHK("nowd_next_ready", req_ready, 4'b1000)
    tick();
    `CHK("nowd_next_src", src_id, 2'd3)
    `CHK("nowd_tmo_end", timeout_err, 1'b0)
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
